// File: rtl/slice_demux_if.sv
// Stream bundle for slice_demux: the raster pixel input stream plus the
// per-slice output streams towards the slice encoder cores.
interface slice_demux_if #(
    parameter int unsigned NBR_SLICES = 2
);
    localparam int unsigned PIX_W = 4 * 3 * 14;

    logic [PIX_W-1:0]            pixs_in;
    logic                        pixs_in_valid;
    logic                        pixs_in_sof;
    logic                        pixs_in_ready;
    logic [NBR_SLICES*PIX_W-1:0] pixs_out_p;
    logic [NBR_SLICES-1:0]       pixs_out_valid;
    logic [NBR_SLICES-1:0]       pixs_out_ready;
    logic [NBR_SLICES-1:0]       pixs_out_sof;
    logic [NBR_SLICES-1:0]       pixs_out_eoc;
    logic [NBR_SLICES-1:0]       pixs_out_eos;

    // master: pixel source together with the slice-core sinks; slave: the distributor
    modport master (
        output pixs_in, pixs_in_valid, pixs_in_sof, pixs_out_ready,
        input  pixs_in_ready, pixs_out_p, pixs_out_valid,
        input  pixs_out_sof, pixs_out_eoc, pixs_out_eos
    );

    modport slave (
        input  pixs_in, pixs_in_valid, pixs_in_sof, pixs_out_ready,
        output pixs_in_ready, pixs_out_p, pixs_out_valid,
        output pixs_out_sof, pixs_out_eoc, pixs_out_eos
    );
endinterface

// File: rtl/slice_demux.sv
// Encoder-side input distributor: splits each raster line into slice chunks and
// steers every beat into a single-entry output register of its slice.
module slice_demux #(
    parameter int unsigned MAX_NBR_SLICES   = 2,
    parameter int unsigned MAX_SLICE_WIDTH  = 2560,
    parameter int unsigned MAX_SLICE_HEIGHT = 2560
) (
    input  logic                                clk_core,
    input  logic                                rst_n,
    input  logic [9:0]                          slices_per_line,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
    input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
    input  logic [15:0]                         frame_height,
    slice_demux_if.slave                        bus,
    output logic                                frame_done,
    output logic                                sof_err
);
    localparam int unsigned PIX_W  = 4 * 3 * 14;
    localparam int unsigned NS     = MAX_NBR_SLICES;
    localparam int unsigned SH_W   = $clog2(MAX_SLICE_HEIGHT);
    localparam int unsigned BEAT_W = $clog2(MAX_SLICE_WIDTH >> 2) + 1;
    localparam int unsigned SEL_W  = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [SH_W-1:0]          line_in_slice_q, line_in_slice_d;
    logic [15:0]              line_tot_q, line_tot_d;
    logic                     frame_done_q, frame_done_d;
    logic                     sof_err_q, sof_err_d;

    logic [NS-1:0]            valid_q, valid_d;
    logic [NS-1:0]            sof_q, sof_d;
    logic [NS-1:0]            eoc_q, eoc_d;
    logic [NS-1:0]            eos_q, eos_d;
    logic [NS-1:0][PIX_W-1:0] data_q, data_d;

    logic                     tgt_valid;
    logic                     tgt_ready;
    logic                     in_ready;
    logic                     accept;
    logic                     restart;
    logic                     route;
    logic [BEAT_W-1:0]        cur_beat;
    logic [SEL_W-1:0]         cur_sel;
    logic [SH_W-1:0]          cur_lis;
    logic [15:0]              cur_ltot;
    logic [31:0]              w4;
    logic                     beat_last;
    logic                     sel_last;
    logic                     lis_last;
    logic                     ltot_last;
    logic [NS-1:0]            wr_vec;
    logic                     wr_sof;
    logic                     wr_eoc;
    logic                     wr_eos;

    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        sel_d           = sel_q;
        line_in_slice_d = line_in_slice_q;
        line_tot_d      = line_tot_q;
        frame_done_d    = 1'b0;
        sof_err_d       = 1'b0;
        wr_vec          = '0;
        wr_sof          = 1'b0;
        wr_eoc          = 1'b0;
        wr_eos          = 1'b0;

        tgt_valid = 1'b0;
        tgt_ready = 1'b0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (sel_q == SEL_W'(s)) begin
                tgt_valid = valid_q[s];
                tgt_ready = bus.pixs_out_ready[s];
            end
        end

        in_ready = (state_q == IDLE) | ~tgt_valid | tgt_ready;
        accept   = bus.pixs_in_valid & in_ready;
        restart  = accept & bus.pixs_in_sof;
        route    = accept & (restart | (state_q == ACTIVE));

        // An accepted SOF is handled as beat 0 of a fresh frame in either state
        cur_beat = restart ? '0 : beat_cnt_q;
        cur_sel  = restart ? '0 : sel_q;
        cur_lis  = restart ? '0 : line_in_slice_q;
        cur_ltot = restart ? '0 : line_tot_q;

        w4        = 32'(slice_width >> 2);
        beat_last = 32'(cur_beat) == (w4 - 32'd1);
        sel_last  = 32'(cur_sel) == (32'(slices_per_line) - 32'd1);
        lis_last  = 32'(cur_lis) == (32'(slice_height) - 32'd1);
        ltot_last = 32'(cur_ltot) == (32'(frame_height) - 32'd1);

        if (route) begin
            for (int unsigned s = 0; s < NS; s++) begin
                if (cur_sel == SEL_W'(s)) begin
                    wr_vec[s] = 1'b1;
                end
            end
            wr_sof    = (cur_lis == '0) & (cur_beat == '0);
            wr_eoc    = beat_last;
            wr_eos    = beat_last & (lis_last | ltot_last);
            sof_err_d = restart & (state_q == ACTIVE);
            state_d   = ACTIVE;

            beat_cnt_d      = cur_beat + BEAT_W'(1);
            sel_d           = cur_sel;
            line_in_slice_d = cur_lis;
            line_tot_d      = cur_ltot;
            if (beat_last) begin
                beat_cnt_d = '0;
                if (sel_last) begin
                    sel_d           = '0;
                    line_in_slice_d = lis_last ? '0 : cur_lis + SH_W'(1);
                    line_tot_d      = cur_ltot + 16'd1;
                end else begin
                    sel_d = cur_sel + SEL_W'(1);
                end
            end

            if (beat_last & sel_last & ltot_last) begin
                state_d         = IDLE;
                frame_done_d    = 1'b1;
                beat_cnt_d      = '0;
                sel_d           = '0;
                line_in_slice_d = '0;
                line_tot_d      = '0;
            end
        end
    end

    // A write and a consume in the same cycle keep the register full with the new beat
    always_comb begin
        valid_d = '0;
        sof_d   = sof_q;
        eoc_d   = eoc_q;
        eos_d   = eos_q;
        data_d  = data_q;
        for (int unsigned s = 0; s < NS; s++) begin
            valid_d[s] = wr_vec[s] | (valid_q[s] & ~bus.pixs_out_ready[s]);
            if (wr_vec[s]) begin
                sof_d[s]  = wr_sof;
                eoc_d[s]  = wr_eoc;
                eos_d[s]  = wr_eos;
                data_d[s] = bus.pixs_in;
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            beat_cnt_q      <= '0;
            sel_q           <= '0;
            line_in_slice_q <= '0;
            line_tot_q      <= '0;
            frame_done_q    <= 1'b0;
            sof_err_q       <= 1'b0;
            valid_q         <= '0;
            sof_q           <= '0;
            eoc_q           <= '0;
            eos_q           <= '0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            sel_q           <= sel_d;
            line_in_slice_q <= line_in_slice_d;
            line_tot_q      <= line_tot_d;
            frame_done_q    <= frame_done_d;
            sof_err_q       <= sof_err_d;
            valid_q         <= valid_d;
            sof_q           <= sof_d;
            eoc_q           <= eoc_d;
            eos_q           <= eos_d;
        end
    end

    always_ff @(posedge clk_core) begin
        data_q <= data_d;
    end

    assign bus.pixs_in_ready  = in_ready;
    assign bus.pixs_out_p     = data_q;
    assign bus.pixs_out_valid = valid_q;
    assign bus.pixs_out_sof   = sof_q;
    assign bus.pixs_out_eoc   = eoc_q;
    assign bus.pixs_out_eos   = eos_q;
    assign frame_done         = frame_done_q;
    assign sof_err            = sof_err_q;
endmodule

// File: tb/tb_slice_demux.sv
// Randomized bench for slice_demux; a frame-index reference model predicts every
// slice beat, marker flag, input ready and frame_done/sof_err pulse.
module tb_slice_demux;
    localparam int unsigned NS       = 2;
    localparam int unsigned PW       = 4 * 3 * 14;
    localparam int unsigned WAIT_MAX = 300;

    typedef logic [PW+2:0] ent_t;

    logic        clk_core = 1'b0;
    logic        rst_n;
    logic [9:0]  slices_per_line;
    logic [11:0] slice_width;
    logic [11:0] slice_height;
    logic [15:0] frame_height;
    logic        frame_done;
    logic        sof_err;

    slice_demux_if #(.NBR_SLICES(NS)) bus ();

    slice_demux #(
        .MAX_NBR_SLICES  (NS),
        .MAX_SLICE_WIDTH (2560),
        .MAX_SLICE_HEIGHT(2560)
    ) dut (
        .clk_core       (clk_core),
        .rst_n          (rst_n),
        .slices_per_line(slices_per_line),
        .slice_width    (slice_width),
        .slice_height   (slice_height),
        .frame_height   (frame_height),
        .bus            (bus),
        .frame_done     (frame_done),
        .sof_err        (sof_err)
    );

    always #5 clk_core = ~clk_core;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, expv);
        end
    endtask

    // Reference model: each beat is located by its index within the frame
    ent_t        expq[NS][$];
    bit          m_active;
    int unsigned m_k;
    bit          fd_exp;
    bit          se_exp;

    function automatic int unsigned w4_of();
        return 32'(slice_width) / 4;
    endfunction

    function automatic int unsigned line_beats();
        return 32'(slices_per_line) * w4_of();
    endfunction

    function automatic bit exp_in_ready();
        int unsigned t;
        if (!m_active) return 1'b1;
        t = (m_k % line_beats()) / w4_of();
        return (expq[t].size() == 0) || (bus.pixs_out_ready[t] == 1'b1);
    endfunction

    task automatic model_accept(input logic [PW-1:0] d, input logic sof);
        int unsigned w4, lb, line, r, s, b, lis;
        bit          e_sof, e_eoc, e_eos;
        if (sof) begin
            if (m_active) se_exp = 1'b1;
            m_k      = 0;
            m_active = 1'b1;
        end else if (!m_active) begin
            return;
        end
        w4    = w4_of();
        lb    = line_beats();
        line  = m_k / lb;
        r     = m_k % lb;
        s     = r / w4;
        b     = r % w4;
        lis   = line % 32'(slice_height);
        e_sof = (lis == 0) && (b == 0);
        e_eoc = (b == w4 - 1);
        e_eos = e_eoc && ((lis == 32'(slice_height) - 1) || (line == 32'(frame_height) - 1));
        expq[s].push_back({e_sof, e_eoc, e_eos, d});
        if (m_k == lb * 32'(frame_height) - 1) begin
            m_active = 1'b0;
            m_k      = 0;
            fd_exp   = 1'b1;
        end else begin
            m_k++;
        end
    endtask

    always @(negedge clk_core) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NS; s++) expq[s].delete();
            m_active = 1'b0;
            m_k      = 0;
            fd_exp   = 1'b0;
            se_exp   = 1'b0;
        end else begin
            chk("frame_done", 192'(frame_done), 192'(fd_exp));
            chk("sof_err", 192'(sof_err), 192'(se_exp));
            fd_exp = 1'b0;
            se_exp = 1'b0;
            chk("in_ready", 192'(bus.pixs_in_ready), 192'(exp_in_ready()));
            for (int unsigned s = 0; s < NS; s++) begin
                chk($sformatf("out_valid[%0d]", s), 192'(bus.pixs_out_valid[s]),
                    192'(expq[s].size() != 0));
                if (bus.pixs_out_valid[s] && expq[s].size() != 0) begin
                    chk($sformatf("out_beat[%0d]", s),
                        192'({bus.pixs_out_sof[s], bus.pixs_out_eoc[s], bus.pixs_out_eos[s],
                              bus.pixs_out_p[s*PW +: PW]}),
                        192'(expq[s][0]));
                    if (bus.pixs_out_ready[s]) void'(expq[s].pop_front());
                end
            end
            if (bus.pixs_in_valid && bus.pixs_in_ready) model_accept(bus.pixs_in, bus.pixs_in_sof);
        end
    end

    // Downstream ready: all-high, random, or slice 1 stalled for 5 cycles once armed
    bit          rand_rdy;
    int unsigned bp_req;

    initial begin : ready_drv
        int unsigned   bp_ack;
        int unsigned   bp_left;
        logic [NS-1:0] rdy;
        bp_ack  = 0;
        bp_left = 0;
        bus.pixs_out_ready = '1;
        forever begin
            @(posedge clk_core);
            #1;
            if (bp_req != bp_ack && bus.pixs_out_valid[1]) begin
                bp_ack  = bp_req;
                bp_left = 5;
            end
            for (int unsigned s = 0; s < NS; s++)
                rdy[s] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bp_left > 0) begin
                rdy[1] = 1'b0;
                bp_left--;
            end
            bus.pixs_out_ready = rdy;
        end
    end

    int unsigned last_waits[64];

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    function automatic logic [PW-1:0] rnd_pix();
        logic [191:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v[PW-1:0];
    endfunction

    task automatic send(input logic [PW-1:0] d, input logic sof, output int unsigned waits);
        bit done;
        waits = 0;
        done  = 1'b0;
        bus.pixs_in       = d;
        bus.pixs_in_sof   = sof;
        bus.pixs_in_valid = 1'b1;
        while (!done) begin
            @(negedge clk_core);
            if (bus.pixs_in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits >= WAIT_MAX) begin
                    chk("send_timeout", 192'(waits), 192'(0));
                    done = 1'b1;
                end
            end
        end
        step();
        bus.pixs_in_valid = 1'b0;
        bus.pixs_in_sof   = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int unsigned s = 0; s < NS; s++)
            if (expq[s].size() != 0) return 1'b0;
        return bus.pixs_out_valid == '0;
    endfunction

    task automatic drain();
        int unsigned n;
        n = 0;
        while (!all_empty() && n < WAIT_MAX) begin
            step();
            n++;
        end
        chk("drain_timeout", 192'(n >= WAIT_MAX), 192'(0));
        step();
        step();
    endtask

    // sof_at: beat index carrying a second, mid-frame SOF (0 = none); n_send: 0 = whole frame
    task automatic run_frame(input int unsigned spl, input int unsigned sw, input int unsigned sh,
                             input int unsigned fh, input int unsigned sof_at,
                             input int unsigned n_send, input bit gaps);
        int unsigned total, n, w;
        slices_per_line = 10'(spl);
        slice_width     = 12'(sw);
        slice_height    = 12'(sh);
        frame_height    = 16'(fh);
        total = spl * (sw / 4) * fh + sof_at;
        n     = (n_send == 0) ? total : n_send;
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            send(rnd_pix(), (i == 0) || (sof_at != 0 && i == sof_at), w);
            if (i < 64) last_waits[i] = w;
        end
    endtask

    initial begin : main
        int unsigned w;
        rst_n             = 1'b0;
        bus.pixs_in       = '0;
        bus.pixs_in_valid = 1'b0;
        bus.pixs_in_sof   = 1'b0;
        rand_rdy          = 1'b0;
        bp_req            = 0;
        slices_per_line   = 10'd2;
        slice_width       = 12'd8;
        slice_height      = 12'd2;
        frame_height      = 16'd2;

        repeat (3) @(posedge clk_core);
        #1;
        chk("rst_valid", 192'(bus.pixs_out_valid), 192'(0));
        chk("rst_flags", 192'({bus.pixs_out_sof, bus.pixs_out_eoc, bus.pixs_out_eos}), 192'(0));
        chk("rst_pulses", 192'({frame_done, sof_err}), 192'(0));
        chk("rst_in_ready", 192'(bus.pixs_in_ready), 192'(1));
        rst_n = 1'b1;
        step();

        for (int unsigned i = 0; i < 3; i++) send(rnd_pix(), 1'b0, w);
        step();
        step();
        chk("idle_drop_valid", 192'(bus.pixs_out_valid), 192'(0));

        run_frame(2, 8, 2, 2, 0, 0, 1'b0);
        drain();

        bp_req++;
        run_frame(2, 8, 2, 2, 0, 0, 1'b0);
        chk("bp_d3_stall_cycles", 192'(last_waits[3]), 192'(5));
        drain();

        run_frame(1, 8, 3, 4, 0, 0, 1'b0);
        drain();

        run_frame(2, 8, 2, 2, 3, 0, 1'b0);
        drain();

        run_frame(2, 8, 2, 2, 0, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 192'(bus.pixs_out_valid), 192'(0));
        chk("arst_flags", 192'({bus.pixs_out_sof, bus.pixs_out_eoc, bus.pixs_out_eos}), 192'(0));
        chk("arst_pulses", 192'({frame_done, sof_err}), 192'(0));
        chk("arst_in_ready", 192'(bus.pixs_in_ready), 192'(1));
        step();
        step();
        rst_n = 1'b1;
        step();
        run_frame(2, 8, 2, 2, 0, 0, 1'b0);
        drain();

        rand_rdy = 1'b1;
        repeat (10) begin
            run_frame($urandom_range(1, 2), 4 * $urandom_range(2, 5), $urandom_range(1, 3),
                      $urandom_range(1, 5), 0, 0, 1'b1);
            drain();
        end
        rand_rdy = 1'b0;
        repeat (3) step();
        for (int unsigned s = 0; s < NS; s++)
            chk($sformatf("leftover[%0d]", s), 192'(expq[s].size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/slice_demux.md
# slice_demux

Encoder-side input distributor. Takes the raster-ordered frame, four pixels per beat, and splits each line into `slices_per_line` chunks. Each chunk is steered to the per-slice output port of its slice, with slice-boundary markers. It sits between the encoder pixel input and the per-slice encoder cores, and is the transmit-side counterpart of the decoder's slice multiplexer.

## Interface
Parameters:
- MAX_NBR_SLICES, 2, number of per-slice output ports
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels
- MAX_SLICE_HEIGHT, 2560, maximum slice height in lines

Ports:
- clk_core  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- slices_per_line  in  10  slices per line, 1..MAX_NBR_SLICES, static during a frame
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels, multiple of 4, ≥8
- slice_height  in  $clog2(MAX_SLICE_HEIGHT)  slice height in lines, ≥1
- frame_height  in  16  frame height in lines, ≥1
- pixs_in  in  4*3*14  4 pixels; pixel p, component c at bits [(p*3+c)*14+:14]
- pixs_in_valid  in  1  input beat valid
- pixs_in_sof  in  1  first beat of frame; qualified by pixs_in_valid
- pixs_in_ready  out  1  input beat accepted when valid & ready
- pixs_out_p  out  MAX_NBR_SLICES*4*3*14  per-slice data; slice s at [s*168+:168]
- pixs_out_valid  out  MAX_NBR_SLICES  per-slice beat valid
- pixs_out_ready  in  MAX_NBR_SLICES  per-slice downstream ready
- pixs_out_sof  out  MAX_NBR_SLICES  first beat of a slice
- pixs_out_eoc  out  MAX_NBR_SLICES  last beat of a chunk (slice line)
- pixs_out_eos  out  MAX_NBR_SLICES  last beat of a slice
- frame_done  out  1  one-cycle pulse after the last beat of the frame is accepted
- sof_err  out  1  one-cycle pulse when SOF arrives mid-frame

## Operation
- State machine:
  - IDLE (reset state). pixs_in_ready=1. Beats without SOF are accepted and dropped. An accepted SOF beat enters ACTIVE and is routed as beat 0.
  - ACTIVE. The last beat of the frame is the beat with beat_cnt=W4-1, sel=slices_per_line-1 and line_tot=frame_height-1. Accepting it returns to IDLE and pulses frame_done the next cycle.
- Counters. All counters update only on input accept. Define W4 = slice_width>>2.
  - beat_cnt, $clog2(MAX_SLICE_WIDTH>>2)+1 bits: 0..W4-1, then wraps to 0 and increments sel.
  - sel, $clog2(MAX_NBR_SLICES) bits: 0..slices_per_line-1, then wraps to 0 and increments line_in_slice and line_tot.
  - line_in_slice: 0..slice_height-1, then wraps.
  - line_tot, 16 bits: counts frame lines.
  - All comparisons are done at full width after zero-extension.
- Routing. The beat is written into the output register of slice `sel`; the data is unchanged.
- pixs_in_ready in ACTIVE is ~pixs_out_valid[sel] | pixs_out_ready[sel]. This is a single-entry pipeline register per slice.
- Marker flags are registered with the data:
  - sof = line_in_slice==0 & beat_cnt==0
  - eoc = beat_cnt==W4-1
  - eos = eoc & (line_in_slice==slice_height-1 | line_tot==frame_height-1)
  - A short final slice row therefore still terminates every slice.
- Mid-frame SOF. An accepted SOF beat in ACTIVE:
  - resets all counters;
  - is routed to slice 0 as beat 0 with sof=1;
  - pulses sof_err.
  - Output registers already holding data keep it until consumed.
- Per-slice output register. It clears valid on ready & valid when no new beat is written to it that cycle. A simultaneous consume and write leaves valid=1 with the new data.

## Timing
- Latency: input accept at cycle n gives pixs_out_valid[sel]=1 at cycle n+1.
- Throughput: one beat per cycle when the target slice's ready is high.
- pixs_in_ready is combinational from the registered pixs_out_valid[sel] and from pixs_out_ready[sel]. There is no path from pixs_in_valid to pixs_in_ready.
- Reset values:
  - all pixs_out_valid, sof, eoc, eos = 0
  - frame_done = sof_err = 0
  - pixs_in_ready = 1 (IDLE)
  - all counters = 0
  - pixs_out_p is not reset.
- Reset mid-frame: asynchronous return to IDLE. In-flight output beats are discarded, since valid is cleared.
- Output data, valid and flags for a slice hold stable while valid & ~ready.

## Test plan
- Basic split, slices_per_line=2, slice_width=8, slice_height=2, frame_height=2, all ready=1, 8 beats D0..D7:
  - slice0 gets D0,D1,D4,D5 and slice1 gets D2,D3,D6,D7.
  - sof on D0/D2; eoc on D1,D3,D5,D7; eos on D5,D7.
  - frame_done pulses one cycle after the D7 accept.
- Backpressure: same config with pixs_out_ready[1]=0 for 5 cycles starting when D2 is registered.
  - D3 is held with pixs_in_ready=0.
  - D2 stays stable on slice1.
  - No beat is lost or duplicated; the order matches the basic case.
- Short last slice row: slice_height=3, frame_height=4, slices_per_line=1, slice_width=8.
  - eos on line-2 last beat and on line-3 last beat.
  - sof on beat 0 of lines 0 and 3.
- Mid-frame SOF: SOF asserted on beat 3 of the basic case.
  - sof_err pulses.
  - The beat goes to slice0 with sof=1, and the counters restart.
- IDLE drop and reset: 3 beats without SOF are sent after reset and are dropped (no output valid). Then rst_n is pulsed low at beat 4 of a frame.
  - All outputs clear asynchronously.
  - A following SOF frame routes correctly from beat 0.
